hyperbus_burst_arb: RTL and testbench
=====================================

# hyperbus_burst_arb

Multi-port front end for the HyperBus controller. It arbitrates `NumPorts` burst-request streams round-robin and range-checks each accepted burst against the chip map. It splits each burst into segments that never cross a `MaxSegLen` boundary or a chip boundary, and reports one completion per original burst. It sits in the system clock domain between the bus-side request decoders and the controller's segment command input.

## Interface
- `NumPorts`, 2: request ports (≥1)
- `NumChips`, 2: chips per PHY (≥1)
- `AddrWidth`, 32: word (16-bit) address width
- `LenWidth`, 8: burst length field width; length encoded as words−1
- `ChipBase`, 'h0: word address of chip 0
- `ChipSpace`, 'h1000: words per chip (power of two)
- `MaxSegLen`, 16: max words per segment (power of two, ≤ `ChipSpace`)
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, synchronous, active-low
- `req_valid_i` in `NumPorts`: request valid per port
- `req_ready_o` out `NumPorts`: request accepted (one-hot or zero)
- `req_addr_i` in `NumPorts`×`AddrWidth`: start word address
- `req_len_i` in `NumPorts`×`LenWidth`: words−1
- `req_write_i` in `NumPorts`: 1 = write
- `seg_valid_o` out 1: segment valid
- `seg_ready_i` in 1: controller accepts segment
- `seg_chip_o` out max(1,clog2(`NumChips`)): chip index
- `seg_addr_o` out clog2(`ChipSpace`): in-chip word offset
- `seg_len_o` out clog2(`MaxSegLen`): segment words−1
- `seg_write_o` out 1: direction
- `seg_port_o` out max(1,clog2(`NumPorts`)): originating port
- `seg_last_o` out 1: final segment of burst
- `seg_done_i` in 1: one-cycle pulse per completed segment, in issue order
- `done_valid_o` out 1: one-cycle burst completion pulse
- `done_port_o` out max(1,clog2(`NumPorts`)): completing port
- `done_err_o` out 1: burst rejected (range error)

## Operation
- FSM: IDLE, SPLIT, WAIT, ERR. One burst in flight.
- IDLE
  - Grant the first valid port at or after the RR pointer.
  - Assert `req_ready_o[g]` combinationally; the handshake latches addr, len, write and port.
  - Pointer ← g+1 mod `NumPorts`.
- Range check at accept, with rel = addr−`ChipBase` and last = rel+len.
  - If addr < `ChipBase` or last ≥ `NumChips`·`ChipSpace`, go to ERR.
  - Otherwise go to SPLIT. Remaining words = len+1.
- SPLIT
  - Segment words = min(remaining, `MaxSegLen` − (rel mod `MaxSegLen`)).
  - Chip boundaries are implied because `MaxSegLen` divides `ChipSpace`.
  - `seg_chip_o` = rel / `ChipSpace`, `seg_addr_o` = rel mod `ChipSpace`, `seg_last_o` = (words == remaining).
  - On each segment handshake: rel += words, remaining −= words, outstanding += 1.
  - On the last-segment handshake, go to WAIT.
- Outstanding counter
  - Decrements on `seg_done_i`. Simultaneous issue and done leaves it unchanged.
  - Width holds ceil(2^`LenWidth`/`MaxSegLen`)+1.
  - `seg_done_i` with outstanding = 0 is ignored.
- WAIT: when all segments are issued and outstanding reaches 0, pulse `done_valid_o` with err = 0, then go to IDLE.
- ERR: issue no segments; pulse `done_valid_o` with `done_err_o` = 1, then go to IDLE.

## Timing
- Reset: all outputs 0, FSM IDLE, RR pointer 0, outstanding 0.
- Reset mid-burst drops the burst silently: no done pulse, and `seg_valid_o` is 0 the next cycle.
- `req_ready_o` is only high in IDLE. Accept in cycle T gives the first `seg_valid_o` at T+1.
- Segment outputs are registered. They hold stable while `seg_valid_o` is high and `seg_ready_i` is low.
- With `seg_ready_i` held high, segments issue back-to-back, one per cycle.
- `seg_done_i` may arrive during SPLIT, including in the same cycle as a segment handshake.
- Normal completion: `done_valid_o` is high in the cycle after the `seg_done_i` that brings outstanding to 0 with all segments issued.
- If the last `seg_done_i` coincides with the last-segment handshake, done is the cycle after the later of the two events that empties the counter.
- ERR: accept at T, `done_valid_o` = 1 and `done_err_o` = 1 at T+1.
- A new accept is possible in the same cycle `done_valid_o` is high.
- `done_port_o` and `done_err_o` are valid only while `done_valid_o` is high, and 0 otherwise.

## Test plan
All scenarios use the defaults, with `seg_ready_i` = 1 unless stated.
- **Aligned single:** port 0, addr 0x20, len 7 → one segment (chip 0, 0x20, len 7, last); `seg_done_i` at cycle D → done port 0, err 0 at D+1.
- **Unaligned split:** addr 0x0C, len 19 → segments (0x0C, len 3), then (0x10, len 15, last) on consecutive cycles; one done after two `seg_done_i`.
- **Chip crossing:** addr 0xFF8, len 15 → (chip 0, 0xFF8, len 7), then (chip 1, 0x000, len 7, last).
- **Range error:** addr 0x1FF8, len 15 → no `seg_valid_o`; done err 1 at accept+1. Also addr 0x2000, len 0 → err.
- **Round-robin under backpressure:**
  - Both ports valid continuously with `seg_ready_i` toggling 0/1 → grants 0,1,0,1.
  - Segment fields stay stable while stalled.
  - A spurious `seg_done_i` in IDLE changes nothing.
- **Reset mid-SPLIT:** `rst_ni` = 0 during the second segment of a 3-segment burst → all outputs 0 next cycle, no done; after release, port 0 is granted first.

Source files
------------

// File: rtl/hyperbus_burst_arb.sv
// HyperBus burst front end: round-robin port arbitration, chip-map range
// check, and splitting of each burst into MaxSegLen-aligned segments, with
// one completion per burst once every issued segment has reported done.
module hyperbus_burst_arb #(
  parameter int                   NumPorts  = 2,
  parameter int                   NumChips  = 2,
  parameter int                   AddrWidth = 32,
  parameter int                   LenWidth  = 8,
  parameter logic [AddrWidth-1:0] ChipBase  = 'h0,
  parameter int                   ChipSpace = 'h1000,
  parameter int                   MaxSegLen = 16,
  localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int ChipW = (NumChips > 1) ? $clog2(NumChips) : 1,
  localparam int OffW  = $clog2(ChipSpace),
  localparam int SegW  = $clog2(MaxSegLen)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                req_valid_i,
  output logic [NumPorts-1:0]                req_ready_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumPorts-1:0][LenWidth-1:0]  req_len_i,
  input  logic [NumPorts-1:0]                req_write_i,
  output logic                               seg_valid_o,
  input  logic                               seg_ready_i,
  output logic [ChipW-1:0]                   seg_chip_o,
  output logic [OffW-1:0]                    seg_addr_o,
  output logic [SegW-1:0]                    seg_len_o,
  output logic                               seg_write_o,
  output logic [PortW-1:0]                   seg_port_o,
  output logic                               seg_last_o,
  input  logic                               seg_done_i,
  output logic                               done_valid_o,
  output logic [PortW-1:0]                   done_port_o,
  output logic                               done_err_o
);

  localparam int RemW = LenWidth + 1;
  localparam int WW   = (RemW > SegW + 1) ? RemW : SegW + 1;
  localparam int OutW = $clog2(((2**LenWidth) + MaxSegLen - 1) / MaxSegLen + 2);
  localparam logic [AddrWidth:0] Span = (AddrWidth+1)'(NumChips * ChipSpace);

  typedef enum logic [1:0] {IDLE, SPLIT, WAIT, ERR} state_e;

  state_e               state_q;
  logic [PortW-1:0]     rr_q, grant;
  logic                 grant_vld, accept, a_err, seg_hs, dn;
  int                   idx;
  logic [AddrWidth-1:0] rel_q, src_rel, a_addr;
  logic [LenWidth-1:0]  a_len;
  logic [AddrWidth:0]   a_last;
  logic [RemW-1:0]      rem_q, src_rem;
  logic [WW-1:0]        cur_words, src_words;
  logic [OutW-1:0]      out_q, out_d;

  // words that fit before the next MaxSegLen boundary, capped by what is left
  function automatic logic [WW-1:0] seg_words(input logic [SegW-1:0] rel_lo,
                                              input logic [RemW-1:0] rem);
    logic [WW-1:0] room;
    room = WW'(MaxSegLen) - WW'(rel_lo);
    return (WW'(rem) < room) ? WW'(rem) : room;
  endfunction

  // round-robin pick: first valid port at or after the pointer
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (!grant_vld && req_valid_i[idx]) begin
        grant     = PortW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // ready only in IDLE, one-hot on the granted port
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == IDLE && grant_vld) req_ready_o[grant] = 1'b1;
  end

  assign accept = |req_ready_o;
  assign a_addr = req_addr_i[grant];
  assign a_len  = req_len_i[grant];
  assign a_last = {1'b0, a_addr - ChipBase} + (AddrWidth+1)'(a_len);
  assign a_err  = (a_addr < ChipBase) || (a_last >= Span);
  assign seg_hs = seg_valid_o && seg_ready_i;
  assign dn     = seg_done_i && (out_q != '0);

  assign cur_words = seg_words(rel_q[SegW-1:0], rem_q);
  assign src_words = seg_words(src_rel[SegW-1:0], src_rem);

  // next segment source: the fresh burst in IDLE, else the cursor advanced past the current segment
  always_comb begin
    src_rel = rel_q + AddrWidth'(cur_words);
    src_rem = rem_q - RemW'(cur_words);
    if (state_q == IDLE) begin
      src_rel = a_addr - ChipBase;
      src_rem = RemW'(a_len) + RemW'(1);
    end
  end

  // outstanding segments; a done that coincides with an issue cancels out
  always_comb begin
    out_d = out_q;
    if (seg_hs && !dn) out_d = out_q + OutW'(1);
    else if (!seg_hs && dn) out_d = out_q - OutW'(1);
  end

  // burst FSM with registered segment and completion outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      out_q        <= '0;
      rel_q        <= '0;
      rem_q        <= '0;
      seg_valid_o  <= 1'b0;
      seg_chip_o   <= '0;
      seg_addr_o   <= '0;
      seg_len_o    <= '0;
      seg_write_o  <= 1'b0;
      seg_port_o   <= '0;
      seg_last_o   <= 1'b0;
      done_valid_o <= 1'b0;
      done_port_o  <= '0;
      done_err_o   <= 1'b0;
    end else begin
      out_q        <= out_d;
      done_valid_o <= 1'b0;
      done_port_o  <= '0;
      done_err_o   <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          rr_q        <= (grant == PortW'(NumPorts - 1)) ? '0 : grant + PortW'(1);
          seg_write_o <= req_write_i[grant];
          seg_port_o  <= grant;
          if (a_err) begin
            state_q      <= ERR;
            done_valid_o <= 1'b1;
            done_err_o   <= 1'b1;
            done_port_o  <= grant;
          end else begin
            state_q     <= SPLIT;
            rel_q       <= src_rel;
            rem_q       <= src_rem;
            seg_valid_o <= 1'b1;
            seg_chip_o  <= ChipW'(src_rel >> OffW);
            seg_addr_o  <= src_rel[OffW-1:0];
            seg_len_o   <= SegW'(src_words - WW'(1));
            seg_last_o  <= (src_words == WW'(src_rem));
          end
        end
        SPLIT: if (seg_hs) begin
          if (seg_last_o) begin
            state_q     <= WAIT;
            seg_valid_o <= 1'b0;
            seg_last_o  <= 1'b0;
          end else begin
            rel_q      <= src_rel;
            rem_q      <= src_rem;
            seg_chip_o <= ChipW'(src_rel >> OffW);
            seg_addr_o <= src_rel[OffW-1:0];
            seg_len_o  <= SegW'(src_words - WW'(1));
            seg_last_o <= (src_words == WW'(src_rem));
          end
        end
        WAIT: if (out_d == '0) begin
          state_q      <= IDLE;
          done_valid_o <= 1'b1;
          done_port_o  <= seg_port_o;
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_arb.sv
// Randomized bench for hyperbus_burst_arb: driver feeds a burst-level model
// that queues expected segments and completions; a monitor pops and compares.
module tb_hyperbus_burst_arb;
  localparam int NP = 2, NC = 2, AW = 32, LW = 8, CS = 'h1000, MS = 16, CB = 0;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NP-1:0]          req_valid_i, req_ready_o, req_write_i;
  logic [NP-1:0][AW-1:0]  req_addr_i;
  logic [NP-1:0][LW-1:0]  req_len_i;
  logic                   seg_valid_o, seg_ready_i, seg_write_o, seg_last_o, seg_done_i;
  logic [0:0]             seg_chip_o, seg_port_o, done_port_o;
  logic [11:0]            seg_addr_o;
  logic [3:0]             seg_len_o;
  logic                   done_valid_o, done_err_o;

  hyperbus_burst_arb #(.NumPorts(NP), .NumChips(NC), .AddrWidth(AW), .LenWidth(LW),
    .ChipBase(32'h0), .ChipSpace(CS), .MaxSegLen(MS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_write_i(req_write_i),
    .seg_valid_o(seg_valid_o), .seg_ready_i(seg_ready_i), .seg_chip_o(seg_chip_o),
    .seg_addr_o(seg_addr_o), .seg_len_o(seg_len_o), .seg_write_o(seg_write_o),
    .seg_port_o(seg_port_o), .seg_last_o(seg_last_o), .seg_done_i(seg_done_i),
    .done_valid_o(done_valid_o), .done_port_o(done_port_o), .done_err_o(done_err_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct packed {int chip; int addr; int len; int wr; int port; int last;} seg_t;
  typedef struct packed {int port; int err; int cyc;} done_t;

  seg_t  seg_q[$];
  done_t done_q[$];
  int    checks = 0, errors = 0;
  int    ptr = 0, pending = 0, segs_left = 0, cur_port = 0, first_seg_cyc = 0;
  int    free_cyc = 0, mode = 1, rdy_mode = 2;
  bit    active = 0, rst_cmd = 0, rst_low_prev = 0, tog = 0;
  bit    dir_go = 0;
  int    dir_p = 0, dir_addr = 0, dir_len = 0;
  logic [NP-1:0] acc = '0;

  task automatic check(input bit ok, input string name, input string info);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  task automatic new_req(input int p);
    int r;
    r = $urandom_range(0, 9);
    req_valid_i[p] = 1'b1;
    req_write_i[p] = 1'($urandom_range(0, 1));
    if (r == 0)     req_addr_i[p] = $urandom();
    else if (r < 3) req_addr_i[p] = $urandom_range('h1f00, 'h2010);
    else            req_addr_i[p] = $urandom_range(0, 'h1fff);
    req_len_i[p] = (r % 2 == 1) ? LW'($urandom_range(0, 255)) : LW'($urandom_range(0, 40));
  endtask

  // burst-level model: range rule, then greedy split at MaxSegLen boundaries
  task automatic model_accept(input int p);
    longint a, rel, rem, w;
    int n;
    n = 0;
    a = longint'(req_addr_i[p]);
    cur_port = p;
    if (a < CB || (a - CB) + longint'(req_len_i[p]) >= NC * CS) begin
      done_q.push_back('{p, 1, cyc + 1});
      free_cyc = cyc + 2;
    end else begin
      rel = a - CB;
      rem = longint'(req_len_i[p]) + 1;
      while (rem > 0) begin
        w = MS - (rel % MS);
        if (rem < w) w = rem;
        seg_q.push_back('{int'(rel / CS), int'(rel % CS), int'(w - 1),
                          int'(req_write_i[p]), p, int'(w == rem)});
        rel += w;
        rem -= w;
        n++;
      end
      segs_left     = n;
      active        = 1;
      first_seg_cyc = cyc + 1;
      free_cyc      = 32'h3fffffff;
    end
    ptr = (p + 1) % NP;
  endtask

  task automatic step();
    bit seg_hs, dn, exp_sv;
    logic [NP-1:0] exp_oh, hs;
    @(negedge clk_i);
    rst_ni = rst_cmd;
    for (int p = 0; p < NP; p++) if (acc[p]) begin req_valid_i[p] = 1'b0; acc[p] = 1'b0; end
    if (dir_go) begin
      dir_go = 0;
      req_valid_i[dir_p] = 1'b1;
      req_addr_i[dir_p]  = AW'(dir_addr);
      req_len_i[dir_p]   = LW'(dir_len);
      req_write_i[dir_p] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      if (mode == 0 && !req_valid_i[p] && $urandom_range(0, 2) == 0) new_req(p);
      if (mode == 2 && !req_valid_i[p]) new_req(p);
    end
    case (rdy_mode)
      0:       seg_ready_i = ($urandom_range(0, 3) != 0);
      1:       begin tog = !tog; seg_ready_i = tog; end
      default: seg_ready_i = 1'b1;
    endcase
    seg_done_i = (pending > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
    #1;
    if (!rst_ni) begin
      if (rst_low_prev)
        check(!seg_valid_o && seg_chip_o == 0 && seg_addr_o == 0 && seg_len_o == 0 &&
              !seg_write_o && seg_port_o == 0 && !seg_last_o && !done_valid_o &&
              done_port_o == 0 && !done_err_o && req_ready_o == 0, "reset_zero",
              $sformatf("seg_valid=%0b done_valid=%0b ready=%b, all required 0",
                        seg_valid_o, done_valid_o, req_ready_o));
      seg_q.delete(); done_q.delete();
      ptr = 0; pending = 0; active = 0; segs_left = 0; free_cyc = 0;
      rst_low_prev = 1;
      return;
    end
    rst_low_prev = 0;
    exp_sv = active && segs_left > 0 && cyc >= first_seg_cyc;
    check(seg_valid_o == exp_sv, "seg_valid",
          $sformatf("got %0b want %0b at cycle %0d", seg_valid_o, exp_sv, cyc));
    seg_hs = seg_valid_o && seg_ready_i;
    dn     = seg_done_i && pending > 0;
    pending += int'(seg_hs) - int'(dn);
    if (seg_hs && active) segs_left--;
    if (active && segs_left == 0 && pending == 0) begin
      done_q.push_back('{cur_port, 0, cyc + 1});
      active   = 0;
      free_cyc = cyc + 1;
    end
    exp_oh = '0;
    if (cyc >= free_cyc)
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (ptr + k) % NP;
        if (req_valid_i[idx] && exp_oh == '0) exp_oh[idx] = 1'b1;
      end
    check(req_ready_o == exp_oh, "grant",
          $sformatf("ready got %b want %b (valid %b) at cycle %0d", req_ready_o, exp_oh, req_valid_i, cyc));
    hs = req_valid_i & req_ready_o;
    for (int p = 0; p < NP; p++) if (hs[p] && hs == (NP'(1) << p)) begin
      model_accept(p);
      acc[p] = 1'b1;
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (n < 2000 && (active || cyc < free_cyc || pending != 0 || req_valid_i != '0 ||
                        seg_q.size() != 0 || done_q.size() != 0)) begin
      step();
      n++;
    end
    check(n < 2000, "quiet_timeout", $sformatf("still busy after %0d cycles, required idle", n));
  endtask

  task automatic directed(input int p, input int addr, input int len);
    mode = 1; dir_p = p; dir_addr = addr; dir_len = len; dir_go = 1;
    step();
    wait_quiet();
  endtask

  // monitor: compares DUT segments and completions against the model queues
  seg_t  prev, cur;
  done_t d;
  bit    stall = 0;
  always @(negedge clk_i) begin
    #2;
    if (!rst_ni) stall = 0;
    else begin
      cur = '{int'(seg_chip_o), int'(seg_addr_o), int'(seg_len_o), int'(seg_write_o),
              int'(seg_port_o), int'(seg_last_o)};
      if (seg_valid_o) begin
        if (stall) check(cur == prev, "seg_stable", $sformatf("got %p held %p", cur, prev));
        if (seg_q.size() == 0) check(0, "seg_unexpected", $sformatf("got %p, none required", cur));
        else begin
          check(cur == seg_q[0], "seg", $sformatf("got %p want %p", cur, seg_q[0]));
          if (seg_ready_i) void'(seg_q.pop_front());
        end
        stall = !seg_ready_i;
        prev  = cur;
      end else begin
        if (stall) check(0, "seg_dropped", "valid fell while stalled, required held");
        stall = 0;
      end
      if (done_valid_o) begin
        if (done_q.size() == 0)
          check(0, "done_unexpected", $sformatf("port %0d err %0b at cycle %0d, none required", done_port_o, done_err_o, cyc));
        else begin
          d = done_q.pop_front();
          check(int'(done_port_o) == d.port && int'(done_err_o) == d.err && cyc == d.cyc, "done",
                $sformatf("got port %0d err %0b cyc %0d want port %0d err %0d cyc %0d",
                          done_port_o, done_err_o, cyc, d.port, d.err, d.cyc));
        end
      end else begin
        check(done_port_o == 0 && !done_err_o, "done_idle_zero",
              $sformatf("port %0d err %0b, required 0", done_port_o, done_err_o));
        if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
          check(0, "done_missing", $sformatf("no done at cycle %0d, required at %0d", cyc, done_q[0].cyc));
          void'(done_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = '0; req_addr_i = '0; req_len_i = '0; req_write_i = '0;
    seg_ready_i = 1'b0; seg_done_i = 1'b0;
    rst_cmd = 0; mode = 1; rdy_mode = 2;
    repeat (3) step();
    rst_cmd = 1;
    // directed bursts
    directed(0, 'h20, 7);
    directed(0, 'h0C, 19);
    directed(1, 'hFF8, 15);
    directed(0, 'h1FF8, 15);
    directed(1, 'h2000, 0);
    // round robin with both ports busy and toggling backpressure
    mode = 2; rdy_mode = 1;
    repeat (80) step();
    mode = 1;
    wait_quiet();
    // random traffic
    mode = 0; rdy_mode = 0;
    repeat (3000) step();
    mode = 1;
    wait_quiet();
    // reset while the second of three segments is presented
    rdy_mode = 2; dir_p = 0; dir_addr = 0; dir_len = 47; dir_go = 1;
    step(); step();
    rst_cmd = 0;
    step(); step();
    rst_cmd = 1;
    mode = 2;
    repeat (30) step();
    mode = 1;
    wait_quiet();
    check(seg_q.size() == 0 && done_q.size() == 0, "drain",
          $sformatf("%0d segments and %0d dones left, required 0", seg_q.size(), done_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
